// File: rtl/multi_button_detect.sv
// rtl/multi_button_detect.sv - per-channel button debouncer with press, release, long-press and auto-repeat pulses
// One shared sample tick drives every channel's debounce, hold and repeat counting.
module multi_button_detect #(
   parameter int N            = 5,
   parameter int TICK_DIV     = 500000,
   parameter int DB_SAMPLES   = 4,
   parameter int HOLD_TICKS   = 200,
   parameter int REPEAT_TICKS = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in,
   input  logic [N-1:0] rpt_en,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] hold,
   output logic [N-1:0] repeat_pulse
);
   localparam int TW = $clog2(TICK_DIV) + 1;
   localparam int DW = $clog2(DB_SAMPLES) + 1;
   localparam int HW = $clog2(HOLD_TICKS) + 1;
   localparam int RW = $clog2(REPEAT_TICKS) + 1;

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

   logic [TW-1:0]         tick_cnt;
   logic                  tick;
   logic [N-1:0]          sync1;
   logic [N-1:0]          sync2;
   logic [N-1:0]          toggle;
   logic [N-1:0]          rise;
   logic [N-1:0]          fall;
   logic [N-1:0][DW-1:0]  db_cnt;
   logic [N-1:0][HW-1:0]  hold_cnt;
   logic [N-1:0][RW-1:0]  rpt_cnt;
   state_t [N-1:0]        state;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         sync1    <= '0;
         sync2    <= '0;
      end else begin
         sync1    <= in;
         sync2    <= sync1;
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end
   end

   // level flips on the tick that brings the DB_SAMPLES-th consecutive differing sample
   always_comb begin
      toggle = '0;
      for (int i = 0; i < N; i++)
         toggle[i] = tick && (sync2[i] != level[i]) && (db_cnt[i] == DW'(DB_SAMPLES - 1));
   end

   assign rise = toggle & ~level;
   assign fall = toggle & level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level         <= '0;
         press         <= '0;
         release_pulse <= '0;
         hold          <= '0;
         repeat_pulse  <= '0;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         rpt_cnt       <= '0;
         for (int i = 0; i < N; i++)
            state[i] <= IDLE;
      end else begin
         level         <= level ^ toggle;
         press         <= rise;
         release_pulse <= fall;
         hold          <= '0;
         repeat_pulse  <= '0;
         for (int i = 0; i < N; i++) begin
            if (tick)
               db_cnt[i] <= ((sync2[i] == level[i]) || toggle[i]) ? '0 : db_cnt[i] + DW'(1);
            // a fall wins over everything so hold/repeat never share the release cycle
            if (fall[i]) begin
               state[i] <= IDLE;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (rise[i]) begin
                        state[i]    <= PRESSED;
                        hold_cnt[i] <= '0;
                     end
                  end
                  PRESSED: begin
                     if (tick) begin
                        if (hold_cnt[i] == HW'(HOLD_TICKS - 1)) begin
                           hold[i]    <= 1'b1;
                           state[i]   <= HELD;
                           rpt_cnt[i] <= '0;
                        end else begin
                           hold_cnt[i] <= hold_cnt[i] + HW'(1);
                        end
                     end
                  end
                  HELD: begin
                     if (!rpt_en[i]) begin
                        rpt_cnt[i] <= '0;
                     end else if (tick) begin
                        if (rpt_cnt[i] == RW'(REPEAT_TICKS - 1)) begin
                           repeat_pulse[i] <= 1'b1;
                           rpt_cnt[i]      <= '0;
                        end else begin
                           rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                        end
                     end
                  end
                  default: state[i] <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: doc/multi_button_detect.md
MULTI_BUTTON_DETECT -- requirements
Module: multi_button_detect

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the number of independent button channels (1..32).
REQ-002 The block SHALL have parameter TICK_DIV, default 500000, giving the clk cycles per sample tick (>=2).
REQ-003 The block SHALL have parameter DB_SAMPLES, default 4, giving the consecutive differing ticks needed to change the debounced level (>=1).
REQ-004 The block SHALL have parameter HOLD_TICKS, default 200, giving the ticks from press to long-press detection (>=1).
REQ-005 The block SHALL have parameter REPEAT_TICKS, default 50, giving the ticks between auto-repeat pulses (>=1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port in, input, N bits: raw asynchronous buttons, active-high.
REQ-009 The block SHALL have port rpt_en, input, N bits: per-channel auto-repeat enable, synchronous to clk.
REQ-010 The block SHALL have port level, output, N bits: debounced button state.
REQ-011 The block SHALL have port press, output, N bits: one-clk pulse on debounced rising edge.
REQ-012 The block SHALL have port release, output, N bits: one-clk pulse on debounced falling edge.
REQ-013 The block SHALL have port hold, output, N bits: one-clk pulse on long-press detection.
REQ-014 The block SHALL have port repeat, output, N bits: one-clk auto-repeat pulses.

Function
REQ-015 Each in bit SHALL pass through a 2-flop synchronizer on clk before any other use.
REQ-016 One shared tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting an internal tick for one cycle when it reaches TICK_DIV-1; the first tick falls TICK_DIV cycles after reset release.
REQ-017 Per channel, on each tick, a synced sample differing from level SHALL increment the debounce count, and a sample equal to level SHALL clear it to 0.
REQ-018 When the debounce count reaches DB_SAMPLES, level SHALL toggle on that tick edge and the count SHALL clear.
REQ-019 press/release SHALL be registered, asserting for exactly one clk cycle in the cycle after level rises or falls.
REQ-020 All outputs SHALL be clk-domain pulses one cycle wide, independent of TICK_DIV; no pulse SHALL ever exceed one cycle.
REQ-021 Each channel SHALL run an FSM with states IDLE, PRESSED and HELD.
REQ-022 IDLE->PRESSED SHALL occur on level rise, clearing the hold counter.
REQ-023 In PRESSED the hold counter SHALL increment once per tick; on reaching HOLD_TICKS the channel SHALL pulse hold, enter HELD and clear the repeat counter.
REQ-024 In HELD with rpt_en=1 the repeat counter SHALL increment per tick, pulsing repeat and clearing at REPEAT_TICKS; while rpt_en=0 it SHALL hold at 0 with no repeat pulses.
REQ-025 On level fall, any state SHALL go to IDLE; hold/repeat SHALL NOT pulse in the cycle release pulses.
REQ-026 Channels SHALL be fully independent; any combination of output bits may pulse in the same cycle.
REQ-027 Input glitches shorter than DB_SAMPLES consecutive ticks SHALL produce no change on any output.
REQ-028 Counter widths SHALL be $clog2 of their limit plus 1; no counter SHALL wrap past its limit.

Reset
REQ-029 While rst=0, all counters, synchronizer flops, FSMs (IDLE) and all outputs SHALL be 0, asynchronously.
REQ-030 Assertion of rst mid-press SHALL clear the channel with no release pulse, and release of rst SHALL produce no pulse while in stays 0.
REQ-031 A button held high through reset release SHALL produce press only after full debounce (DB_SAMPLES ticks).

Verification (TICK_DIV=4, DB_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2, N=2)
REQ-032 Clean press: in[0] 0->1 held -> press[0] is exactly one cycle, within 3+2*4 to 3+3*4+1 cycles of the edge, and level[0]=1 thereafter.
REQ-033 Bounce: in[0] toggles every 3 cycles for 40 cycles, then holds at 0 -> press, release and level all remain 0.
REQ-034 Long press with rpt_en[0]=1: held 60 cycles -> hold[0] pulses once 5 ticks after press, then repeat[0] pulses every 8 cycles until release.
REQ-035 rpt_en[1]=0, in[1] held -> hold[1] pulses once with no repeat[1]; on release, release[1] pulses once and the FSM returns to IDLE.
REQ-036 Simultaneous: both in bits rise in the same cycle -> press=2'b11 in a single cycle.
REQ-037 Reset mid-HELD: rst=0 for 2 cycles -> all outputs 0 immediately, with no release pulse afterward.
